// File: rtl/jtdd_rom_arb.sv
// rtl/jtdd_rom_arb.sv - SDRAM ROM fetch arbiter for char/scroll/object with one-word caches
//
// Purpose: serves three graphics ROM readers from a single SDRAM read port.
// Each reader has a one-word cache; misses are fetched through a
// request/ack/data_rdy handshake with round-robin arbitration.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   downloading                ROM download active: caches invalidated, no fetches
//   char_cs/addr/data/ok       char reader (byte address, byte data)
//   scr_cs/addr/data/ok        scroll reader (word address, word data)
//   obj_cs/addr/data/ok        object reader (word address, word data)
//   sdram_req/addr             read request and word address towards SDRAM
//   sdram_ack, data_rdy        request accepted / read data valid pulses
//   sdram_din                  SDRAM read data

module jtdd_rom_arb #(
  parameter logic [21:0] CHAR_OFFSET = 22'h00000,
  parameter logic [21:0] SCR_OFFSET  = 22'h04000,
  parameter logic [21:0] OBJ_OFFSET  = 22'h24000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic        char_cs,
  input  logic [14:0] char_addr,
  output logic [7:0]  char_data,
  output logic        char_ok,
  input  logic        scr_cs,
  input  logic [16:0] scr_addr,
  output logic [15:0] scr_data,
  output logic        scr_ok,
  input  logic        obj_cs,
  input  logic [17:0] obj_addr,
  output logic [15:0] obj_data,
  output logic        obj_ok,
  output logic        sdram_req,
  output logic [21:0] sdram_addr,
  input  logic        sdram_ack,
  input  logic        data_rdy,
  input  logic [15:0] sdram_din
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_ACK  = 2'd1;
  localparam logic [1:0] ST_WAIT_DATA = 2'd2;

  localparam logic [1:0] SEL_OBJ  = 2'd0;
  localparam logic [1:0] SEL_SCR  = 2'd1;
  localparam logic [1:0] SEL_CHAR = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  rr_q, rr_d;       // requester with highest priority at next grant
  logic [1:0]  gnt_q, gnt_d;     // owner of the fetch in flight
  logic [17:0] lat_q, lat_d;     // un-offset word address of the fetch in flight
  logic        req_q, req_d;
  logic [21:0] addr_q, addr_d;

  logic [13:0] char_word_q, char_word_d;
  logic [15:0] char_dat_q, char_dat_d;
  logic        char_vld_q, char_vld_d;
  logic [16:0] scr_word_q, scr_word_d;
  logic [15:0] scr_dat_q, scr_dat_d;
  logic        scr_vld_q, scr_vld_d;
  logic [17:0] obj_word_q, obj_word_d;
  logic [15:0] obj_dat_q, obj_dat_d;
  logic        obj_vld_q, obj_vld_d;

  logic [13:0] char_cur;
  logic        pend_char, pend_scr, pend_obj;
  logic [1:0]  sel;
  logic [17:0] sel_word;
  logic [21:0] sel_off;
  logic [21:0] fetch_addr;
  logic        fill;

  assign char_cur = char_addr[14:1];

  assign char_ok = char_cs & char_vld_q & (char_word_q == char_cur);
  assign scr_ok  = scr_cs  & scr_vld_q  & (scr_word_q  == scr_addr);
  assign obj_ok  = obj_cs  & obj_vld_q  & (obj_word_q  == obj_addr);

  assign char_data = char_addr[0] ? char_dat_q[15:8] : char_dat_q[7:0];
  assign scr_data  = scr_dat_q;
  assign obj_data  = obj_dat_q;

  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;

  assign pend_char = char_cs & ~char_ok;
  assign pend_scr  = scr_cs  & ~scr_ok;
  assign pend_obj  = obj_cs  & ~obj_ok;

  // Round-robin pick: scan obj -> scr -> char starting at rr_q.
  always_comb begin
    sel = SEL_OBJ;
    case (rr_q)
      SEL_SCR: begin
        if (pend_scr)       sel = SEL_SCR;
        else if (pend_char) sel = SEL_CHAR;
        else                sel = SEL_OBJ;
      end
      SEL_CHAR: begin
        if (pend_char)      sel = SEL_CHAR;
        else if (pend_obj)  sel = SEL_OBJ;
        else                sel = SEL_SCR;
      end
      default: begin
        if (pend_obj)       sel = SEL_OBJ;
        else if (pend_scr)  sel = SEL_SCR;
        else                sel = SEL_CHAR;
      end
    endcase
  end

  always_comb begin
    sel_word = obj_addr;
    sel_off  = OBJ_OFFSET;
    case (sel)
      SEL_SCR: begin
        sel_word = {1'b0, scr_addr};
        sel_off  = SCR_OFFSET;
      end
      SEL_CHAR: begin
        sel_word = {4'd0, char_cur};
        sel_off  = CHAR_OFFSET;
      end
      default: begin
        sel_word = obj_addr;
        sel_off  = OBJ_OFFSET;
      end
    endcase
  end

  // 22-bit sum, wraps naturally
  assign fetch_addr = {4'd0, sel_word} + sel_off;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    gnt_d       = gnt_q;
    lat_d       = lat_q;
    req_d       = req_q;
    addr_d      = addr_q;
    char_word_d = char_word_q;
    char_dat_d  = char_dat_q;
    char_vld_d  = char_vld_q;
    scr_word_d  = scr_word_q;
    scr_dat_d   = scr_dat_q;
    scr_vld_d   = scr_vld_q;
    obj_word_d  = obj_word_q;
    obj_dat_d   = obj_dat_q;
    obj_vld_d   = obj_vld_q;
    fill        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!downloading && (pend_char || pend_scr || pend_obj)) begin
          gnt_d   = sel;
          lat_d   = sel_word;
          addr_d  = fetch_addr;
          req_d   = 1'b1;
          rr_d    = (sel == SEL_OBJ) ? SEL_SCR : ((sel == SEL_SCR) ? SEL_CHAR : SEL_OBJ);
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (sdram_ack) begin
          req_d = 1'b0;
          // data may come back in the same cycle as the ack
          if (data_rdy) begin
            fill    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_DATA;
          end
        end
      end
      ST_WAIT_DATA: begin
        if (data_rdy) begin
          fill    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // Fill with the address latched at grant time, so a reader that moved
    // on mid-fetch still misses and gets re-requested.
    if (fill) begin
      case (gnt_q)
        SEL_SCR: begin
          scr_word_d = lat_q[16:0];
          scr_dat_d  = sdram_din;
          scr_vld_d  = 1'b1;
        end
        SEL_CHAR: begin
          char_word_d = lat_q[13:0];
          char_dat_d  = sdram_din;
          char_vld_d  = 1'b1;
        end
        default: begin
          obj_word_d = lat_q;
          obj_dat_d  = sdram_din;
          obj_vld_d  = 1'b1;
        end
      endcase
    end

    // A download overrides everything, including a fill landing this cycle.
    if (downloading) begin
      char_vld_d = 1'b0;
      scr_vld_d  = 1'b0;
      obj_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_q        <= SEL_OBJ;
      gnt_q       <= SEL_OBJ;
      lat_q       <= '0;
      req_q       <= 1'b0;
      addr_q      <= '0;
      char_word_q <= '0;
      char_dat_q  <= '0;
      char_vld_q  <= 1'b0;
      scr_word_q  <= '0;
      scr_dat_q   <= '0;
      scr_vld_q   <= 1'b0;
      obj_word_q  <= '0;
      obj_dat_q   <= '0;
      obj_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      gnt_q       <= gnt_d;
      lat_q       <= lat_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      char_word_q <= char_word_d;
      char_dat_q  <= char_dat_d;
      char_vld_q  <= char_vld_d;
      scr_word_q  <= scr_word_d;
      scr_dat_q   <= scr_dat_d;
      scr_vld_q   <= scr_vld_d;
      obj_word_q  <= obj_word_d;
      obj_dat_q   <= obj_dat_d;
      obj_vld_q   <= obj_vld_d;
    end
  end

endmodule

// File: tb/tb_jtdd_rom_arb.sv
// tb/tb_jtdd_rom_arb.sv - self-checking bench for jtdd_rom_arb

module tb_jtdd_rom_arb;

  localparam logic [21:0] CHAR_OFF = 22'h00000;
  localparam logic [21:0] SCR_OFF  = 22'h04000;
  localparam logic [21:0] OBJ_OFF  = 22'h24000;

  logic        clk;
  logic        rst_n;
  logic        downloading;
  logic        char_cs;
  logic [14:0] char_addr;
  logic [7:0]  char_data;
  logic        char_ok;
  logic        scr_cs;
  logic [16:0] scr_addr;
  logic [15:0] scr_data;
  logic        scr_ok;
  logic        obj_cs;
  logic [17:0] obj_addr;
  logic [15:0] obj_data;
  logic        obj_ok;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack;
  logic        data_rdy;
  logic [15:0] sdram_din;

  int total = 0;
  int bad   = 0;
  bit auto_rsp;

  // Reference model: per-reader cache contents, next reader in the
  // round-robin order (0=obj, 1=scr, 2=char), and the fetch in flight.
  bit          m_vld[3];
  logic [17:0] m_word[3];
  logic [15:0] m_data[3];
  int          m_next;
  bit          m_busy;
  bit          m_acked;
  int          m_own;
  logic [17:0] m_oword;

  logic [17:0] obj_pool[4];
  logic [16:0] scr_pool[4];
  logic [14:0] char_pool[4];

  jtdd_rom_arb #(
    .CHAR_OFFSET(CHAR_OFF),
    .SCR_OFFSET (SCR_OFF),
    .OBJ_OFFSET (OBJ_OFF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .downloading(downloading),
    .char_cs    (char_cs),
    .char_addr  (char_addr),
    .char_data  (char_data),
    .char_ok    (char_ok),
    .scr_cs     (scr_cs),
    .scr_addr   (scr_addr),
    .scr_data   (scr_data),
    .scr_ok     (scr_ok),
    .obj_cs     (obj_cs),
    .obj_addr   (obj_addr),
    .obj_data   (obj_data),
    .obj_ok     (obj_ok),
    .sdram_req  (sdram_req),
    .sdram_addr (sdram_addr),
    .sdram_ack  (sdram_ack),
    .data_rdy   (data_rdy),
    .sdram_din  (sdram_din)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [17:0] cur_word(input int r);
    case (r)
      0:       return obj_addr;
      1:       return {1'b0, scr_addr};
      default: return {4'd0, char_addr[14:1]};
    endcase
  endfunction

  function automatic logic cs_of(input int r);
    case (r)
      0:       return obj_cs;
      1:       return scr_cs;
      default: return char_cs;
    endcase
  endfunction

  function automatic logic [21:0] off_of(input int r);
    case (r)
      0:       return OBJ_OFF;
      1:       return SCR_OFF;
      default: return CHAR_OFF;
    endcase
  endfunction

  function automatic logic exp_ok(input int r);
    return cs_of(r) && m_vld[r] && (m_word[r] == cur_word(r));
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 3; r++) begin
      m_vld[r]  = 1'b0;
      m_word[r] = '0;
      m_data[r] = '0;
    end
    m_next  = 0;
    m_busy  = 1'b0;
    m_acked = 1'b0;
    m_own   = 0;
    m_oword = '0;
  endtask

  task automatic check_outputs();
    logic [21:0] ea;
    logic [15:0] cd;
    chk("obj_ok",  32'(obj_ok),  32'(exp_ok(0)));
    chk("scr_ok",  32'(scr_ok),  32'(exp_ok(1)));
    chk("char_ok", 32'(char_ok), 32'(exp_ok(2)));
    if (exp_ok(0)) chk("obj_data", 32'(obj_data), 32'(m_data[0]));
    if (exp_ok(1)) chk("scr_data", 32'(scr_data), 32'(m_data[1]));
    cd = m_data[2];
    if (exp_ok(2)) chk("char_data", 32'(char_data), char_addr[0] ? 32'(cd[15:8]) : 32'(cd[7:0]));
    chk("sdram_req", 32'(sdram_req), 32'(m_busy && !m_acked));
    if (m_busy && !m_acked) begin
      ea = {4'd0, m_oword} + off_of(m_own);
      chk("sdram_addr", 32'(sdram_addr), 32'(ea));
    end
  endtask

  // Advance the model over one clock edge using the inputs currently applied.
  task automatic model_update();
    bit pend[3];
    int g;
    for (int r = 0; r < 3; r++) pend[r] = cs_of(r) && !exp_ok(r);
    if (m_busy) begin
      if ((m_acked || sdram_ack) && data_rdy) begin
        m_word[m_own] = m_oword;
        m_data[m_own] = sdram_din;
        m_vld[m_own]  = !downloading;
        m_busy        = 1'b0;
      end else if (sdram_ack) begin
        m_acked = 1'b1;
      end
    end else if (!downloading && (pend[0] || pend[1] || pend[2])) begin
      g = -1;
      for (int k = 0; k < 3; k++)
        if (g < 0 && pend[(m_next + k) % 3]) g = (m_next + k) % 3;
      m_busy  = 1'b1;
      m_acked = 1'b0;
      m_own   = g;
      m_oword = cur_word(g);
      m_next  = (g + 1) % 3;
    end
    if (downloading)
      for (int r = 0; r < 3; r++) m_vld[r] = 1'b0;
  endtask

  // One clock: optional random SDRAM response, check mid-cycle, step model.
  task automatic cyc();
    logic [31:0] t;
    if (auto_rsp) begin
      sdram_ack = m_busy && !m_acked && ($urandom_range(0, 2) == 0);
      data_rdy  = m_busy && (m_acked || sdram_ack) && ($urandom_range(0, 2) == 0);
      t = $urandom;
      sdram_din = t[15:0];
    end
    @(negedge clk);
    #1;
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs();
    chk("rst_req",      32'(sdram_req),  32'(0));
    chk("rst_addr",     32'(sdram_addr), 32'(0));
    chk("rst_char_ok",  32'(char_ok),    32'(0));
    chk("rst_scr_ok",   32'(scr_ok),     32'(0));
    chk("rst_obj_ok",   32'(obj_ok),     32'(0));
    chk("rst_char_dat", 32'(char_data),  32'(0));
    chk("rst_scr_dat",  32'(scr_data),   32'(0));
    chk("rst_obj_dat",  32'(obj_data),   32'(0));
  endtask

  task automatic rand_inputs();
    logic [31:0] t;
    logic [14:0] cp;
    if ($urandom_range(0, 5) == 0) obj_cs  = !obj_cs;
    if ($urandom_range(0, 5) == 0) scr_cs  = !scr_cs;
    if ($urandom_range(0, 5) == 0) char_cs = !char_cs;
    if ($urandom_range(0, 7) == 0) obj_addr = obj_pool[$urandom_range(0, 3)];
    if ($urandom_range(0, 7) == 0) scr_addr = scr_pool[$urandom_range(0, 3)];
    if ($urandom_range(0, 5) == 0) begin
      cp = char_pool[$urandom_range(0, 3)];
      t = $urandom;
      char_addr = {cp[14:1], t[0]};
    end
    if (downloading ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 59) == 0))
      downloading = !downloading;
  endtask

  initial begin
    logic [31:0] t;
    logic [21:0] exp_order[3];

    auto_rsp    = 1'b0;
    rst_n       = 1'b0;
    downloading = 1'b0;
    char_cs     = 1'b1;
    scr_cs      = 1'b1;
    obj_cs      = 1'b1;
    char_addr   = '0;
    scr_addr    = '0;
    obj_addr    = '0;
    sdram_ack   = 1'b0;
    data_rdy    = 1'b0;
    sdram_din   = '0;
    for (int i = 0; i < 4; i++) begin
      t = $urandom; obj_pool[i]  = t[17:0];
      t = $urandom; scr_pool[i]  = t[16:0];
      t = $urandom; char_pool[i] = t[14:0];
    end
    obj_pool[0]  = '0; obj_pool[1]  = 18'h3FFFF;
    scr_pool[0]  = '0; scr_pool[1]  = 17'h1FFFF;
    char_pool[0] = '0; char_pool[1] = 15'h7FFF;
    model_reset();

    // reset state, readers requesting address 0 which matches the cleared cache
    #2;
    check_reset_outs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_reset_outs();
    rst_n   = 1'b1;
    char_cs = 1'b0;
    scr_cs  = 1'b0;
    obj_cs  = 1'b0;
    cyc();

    // char miss, fill, high byte selected
    char_cs   = 1'b1;
    char_addr = 15'h0003;
    cyc();
    chk("c_req", 32'(sdram_req), 32'(1));
    chk("c_addr", 32'(sdram_addr), 32'(22'h000001));
    sdram_ack = 1'b1; cyc(); sdram_ack = 1'b0;
    chk("c_ok_before_data", 32'(char_ok), 32'(0));
    data_rdy = 1'b1; sdram_din = 16'hA55A; cyc(); data_rdy = 1'b0;
    chk("c_ok", 32'(char_ok), 32'(1));
    chk("c_data_hi", 32'(char_data), 32'(8'hA5));

    // same-word reuse, low byte, no new request
    char_addr = 15'h0002;
    #1;
    chk("c_reuse_ok", 32'(char_ok), 32'(1));
    chk("c_reuse_lo", 32'(char_data), 32'(8'h5A));
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("c_reuse_noreq", 32'(sdram_req), 32'(0));
    end

    // three simultaneous misses: obj, scr, char order
    obj_cs = 1'b1; obj_addr = 18'h00010;
    scr_cs = 1'b1; scr_addr = 17'h00020;
    char_addr = 15'h0100;
    exp_order[0] = 22'h024010;
    exp_order[1] = 22'h004020;
    exp_order[2] = 22'h000080;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rr_order", 32'(sdram_addr), 32'(exp_order[i]));
      sdram_ack = 1'b1; cyc(); sdram_ack = 1'b0;
      data_rdy = 1'b1; sdram_din = 16'h1000 + 16'(i); cyc(); data_rdy = 1'b0;
    end
    chk("rr_obj_ok", 32'(obj_ok), 32'(1));
    chk("rr_obj_data", 32'(obj_data), 32'(16'h1000));

    // scroll address moves while its fetch waits for data
    scr_addr = 17'h00100;
    cyc();
    chk("s_addr1", 32'(sdram_addr), 32'(22'h004100));
    sdram_ack = 1'b1; cyc(); sdram_ack = 1'b0;
    scr_addr = 17'h00200;
    data_rdy = 1'b1; sdram_din = 16'h1234; cyc(); data_rdy = 1'b0;
    chk("s_stale_ok", 32'(scr_ok), 32'(0));
    cyc();
    chk("s_rereq", 32'(sdram_req), 32'(1));
    chk("s_addr2", 32'(sdram_addr), 32'(22'h004200));
    sdram_ack = 1'b1; cyc(); sdram_ack = 1'b0;
    data_rdy = 1'b1; sdram_din = 16'h4321; cyc(); data_rdy = 1'b0;
    chk("s_ok", 32'(scr_ok), 32'(1));
    chk("s_data", 32'(scr_data), 32'(16'h4321));

    // download invalidates and blocks; obj alone is granted afterwards
    scr_cs = 1'b0; char_cs = 1'b0;
    downloading = 1'b1;
    cyc();
    chk("d_obj_ok", 32'(obj_ok), 32'(0));
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("d_noreq", 32'(sdram_req), 32'(0));
    end
    downloading = 1'b0;
    cyc();
    chk("d_req", 32'(sdram_req), 32'(1));
    chk("d_addr", 32'(sdram_addr), 32'(22'h024010));
    sdram_ack = 1'b1; data_rdy = 1'b1; sdram_din = 16'hBEEF; cyc();
    sdram_ack = 1'b0; data_rdy = 1'b0;
    chk("d_obj_ok2", 32'(obj_ok), 32'(1));
    chk("d_obj_data", 32'(obj_data), 32'(16'hBEEF));

    // reset pulse while waiting for ack, then a stray data_rdy
    obj_addr = 18'h3FFFF;
    cyc();
    chk("r_addr", 32'(sdram_addr), 32'(22'h063FFF));
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outs();
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("r_idle", 32'(sdram_req), 32'(0));
    data_rdy = 1'b1; sdram_din = 16'hFFFF;
    cyc();
    data_rdy = 1'b0;
    chk("r_rereq", 32'(sdram_req), 32'(1));
    chk("r_addr2", 32'(sdram_addr), 32'(22'h063FFF));

    // randomized traffic against the model
    auto_rsp = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      rand_inputs();
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
